// File: rtl/popcount_pkg.sv
// popcount_pkg: shared types and helpers
// for the popcount CFU and its count tree.
package popcount_pkg;

  localparam int CFU_STATUS_W = 3;

  localparam logic [CFU_STATUS_W-1:0]
    CFU_OK = 3'd0;
  localparam logic [CFU_STATUS_W-1:0]
    CFU_ERROR_CUSTOM = 3'd2;

  typedef enum logic [2:0] {
    POP    = 3'd0,
    POPAND = 3'd1,
    HAMM   = 3'd2,
    ACC    = 3'd3,
    ACCRD  = 3'd4
  } func_e;

  function automatic int count_w(
    input int w
  );
    return $clog2(w + 1);
  endfunction

  function automatic bit legal_w(
    input int w
  );
    return (w == 32) || (w == 64) ||
           (w == 128);
  endfunction

  function automatic logic [2:0] pop6(
    input logic [5:0] x
  );
    logic [2:0] s;
    s = '0;
    for (int i = 0; i < 6; i++)
      s = s + {2'b00, x[i]};
    return s;
  endfunction

endpackage

// File: rtl/popcount_tree.sv
// popcount_tree: 6:3 compressors, 4-way adds
// and a final adder, optionally registered.
module popcount_tree
  import popcount_pkg::*;
#(
  parameter int W    = 32,
  parameter int PIPE = 2,
  parameter int FW   = 3,
  localparam int CW  = count_w(W)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_adv,
  input  logic          i_valid,
  input  logic [FW-1:0] i_func,
  input  logic [W-1:0]  i_data,
  output logic          o_valid,
  output logic [FW-1:0] o_func,
  output logic [CW-1:0] o_count
);

  localparam int N2 = (W + 23) / 24;
  localparam int N1 = 4 * N2;
  localparam int PW = 6 * N1;

  logic [PW-1:0]      w_pad;
  logic [N1-1:0][2:0] w_c1;
  logic [N1-1:0][2:0] w_s1;
  logic [N2-1:0][4:0] w_c2;
  logic [N2-1:0][4:0] w_s2;
  logic [CW-1:0]      w_c3;
  logic               w_v1;
  logic               w_v2;
  logic [FW-1:0]      w_f1;
  logic [FW-1:0]      w_f2;

  assign w_pad = PW'(i_data);

  // level 1: six-bit slices to 3-bit counts
  always_comb begin
    w_c1 = '0;
    for (int g = 0; g < N1; g++)
      w_c1[g] = pop6(w_pad[6*g +: 6]);
  end

  if (PIPE >= 1) begin : g_s1
    logic               r_v;
    logic [FW-1:0]      r_f;
    logic [N1-1:0][2:0] r_c;
    // stage 1 register
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_v <= 1'b0;
        r_f <= '0;
        r_c <= '0;
      end else if (i_adv) begin
        r_v <= i_valid;
        r_f <= i_func;
        r_c <= w_c1;
      end
    end
    assign w_v1 = r_v;
    assign w_f1 = r_f;
    assign w_s1 = r_c;
  end else begin : g_n1
    assign w_v1 = i_valid;
    assign w_f1 = i_func;
    assign w_s1 = w_c1;
  end

  // level 2: sum groups of four counts
  always_comb begin
    w_c2 = '0;
    for (int j = 0; j < N2; j++)
      w_c2[j] = 5'(w_s1[4*j])
              + 5'(w_s1[4*j+1])
              + 5'(w_s1[4*j+2])
              + 5'(w_s1[4*j+3]);
  end

  if (PIPE >= 2) begin : g_s2
    logic               r_v;
    logic [FW-1:0]      r_f;
    logic [N2-1:0][4:0] r_c;
    // stage 2 register
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_v <= 1'b0;
        r_f <= '0;
        r_c <= '0;
      end else if (i_adv) begin
        r_v <= w_v1;
        r_f <= w_f1;
        r_c <= w_c2;
      end
    end
    assign w_v2 = r_v;
    assign w_f2 = r_f;
    assign w_s2 = r_c;
  end else begin : g_n2
    assign w_v2 = w_v1;
    assign w_f2 = w_f1;
    assign w_s2 = w_c2;
  end

  // level 3: final adder
  always_comb begin
    w_c3 = '0;
    for (int j = 0; j < N2; j++)
      w_c3 = w_c3 + CW'(w_s2[j]);
  end

  if (PIPE >= 3) begin : g_s3
    logic          r_v;
    logic [FW-1:0] r_f;
    logic [CW-1:0] r_c;
    // stage 3 register
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_v <= 1'b0;
        r_f <= '0;
        r_c <= '0;
      end else if (i_adv) begin
        r_v <= w_v2;
        r_f <= w_f2;
        r_c <= w_c3;
      end
    end
    assign o_valid = r_v;
    assign o_func  = r_f;
    assign o_count = r_c;
  end else begin : g_n3
    assign o_valid = w_v2;
    assign o_func  = w_f2;
    assign o_count = w_c3;
  end

endmodule

// File: rtl/popcount_l2_cfu.sv
// popcount_l2_cfu: pipelined popcount CFU with
// masked/hamming modes and an accumulator.
module popcount_l2_cfu
  import popcount_pkg::*;
#(
  parameter int CFU_DATA_W    = 32,
  parameter int CFU_CFU_ID_W  = 0,
  parameter int CFU_FUNC_ID_W = 3,
  parameter int PIPE          = 2,
  localparam int CID_W =
    (CFU_CFU_ID_W > 0) ? CFU_CFU_ID_W : 1,
  localparam int FW = CFU_FUNC_ID_W,
  localparam int DW = CFU_DATA_W,
  localparam int CW = count_w(CFU_DATA_W)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [CID_W-1:0]        req_cfu,
  input  logic [FW-1:0]           req_func,
  input  logic [DW-1:0]           req_data0,
  input  logic [DW-1:0]           req_data1,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [CFU_STATUS_W-1:0] resp_status,
  output logic [DW-1:0]           resp_data
);

  if (!legal_w(CFU_DATA_W)) begin : g_bad_w
    $error("CFU_DATA_W must be 32, 64 or 128");
  end
  if (CFU_FUNC_ID_W < 3) begin : g_bad_f
    $error("CFU_FUNC_ID_W must be >= 3");
  end
  if (PIPE < 0 || PIPE > 3) begin : g_bad_p
    $error("PIPE must be 0..3");
  end

  logic                    w_adv;
  logic                    w_fand;
  logic                    w_fxor;
  logic [DW-1:0]           w_op;
  logic                    w_t_valid;
  logic [FW-1:0]           w_t_func;
  logic [CW-1:0]           w_t_count;
  logic [DW-1:0]           w_cnt;
  logic                    w_is_cnt;
  logic                    w_is_acc;
  logic                    w_is_rd;
  logic [DW-1:0]           w_data_nxt;
  logic [DW-1:0]           w_acc_nxt;
  logic [CFU_STATUS_W-1:0] w_stat_nxt;
  logic                    w_unused;

  logic                    r_resp_valid;
  logic [CFU_STATUS_W-1:0] r_status;
  logic [DW-1:0]           r_data;
  logic [DW-1:0]           r_acc;

  assign w_unused = ^req_cfu;

  assign w_adv     = !r_resp_valid || resp_ready;
  assign req_ready = w_adv;

  assign w_fand = req_func == FW'(POPAND);
  assign w_fxor = req_func == FW'(HAMM);

  // operand pre-combine per function
  always_comb begin
    w_op = req_data0;
    unique case (1'b1)
      w_fand:  w_op = req_data0 & req_data1;
      w_fxor:  w_op = req_data0 ^ req_data1;
      default: w_op = req_data0;
    endcase
  end

  popcount_tree #(
    .W    (DW),
    .PIPE (PIPE),
    .FW   (FW)
  ) u_tree (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_adv   (w_adv),
    .i_valid (req_valid && w_adv),
    .i_func  (req_func),
    .i_data  (w_op),
    .o_valid (w_t_valid),
    .o_func  (w_t_func),
    .o_count (w_t_count)
  );

  assign w_cnt    = DW'(w_t_count);
  assign w_is_cnt = (w_t_func == FW'(POP))
                 || (w_t_func == FW'(POPAND))
                 || (w_t_func == FW'(HAMM));
  assign w_is_acc = w_t_func == FW'(ACC);
  assign w_is_rd  = w_t_func == FW'(ACCRD);

  // result, status and next accumulator
  always_comb begin
    w_data_nxt = '0;
    w_stat_nxt = CFU_OK;
    w_acc_nxt  = r_acc;
    unique case (1'b1)
      w_is_cnt: w_data_nxt = w_cnt;
      w_is_acc: begin
        w_acc_nxt  = r_acc + w_cnt;
        w_data_nxt = r_acc + w_cnt;
      end
      w_is_rd: begin
        w_data_nxt = r_acc;
        w_acc_nxt  = '0;
      end
      default: w_stat_nxt = CFU_ERROR_CUSTOM;
    endcase
  end

  // output register and accumulator
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_resp_valid <= 1'b0;
      r_status     <= CFU_OK;
      r_data       <= '0;
      r_acc        <= '0;
    end else if (w_adv) begin
      r_resp_valid <= w_t_valid;
      if (w_t_valid) begin
        r_status <= w_stat_nxt;
        r_data   <= w_data_nxt;
        r_acc    <= w_acc_nxt;
      end
    end
  end

  assign resp_valid  = r_resp_valid;
  assign resp_status = r_status;
  assign resp_data   = r_data;

endmodule

// File: tb/tb_popcount_l2_cfu.sv
// tb_popcount_l2_cfu: vector table plus
// scoreboard for W=32/PIPE=2 and W=64/PIPE=0.
module tb_popcount_l2_cfu;
  import popcount_pkg::*;

  localparam int P32 = 2;
  localparam int P64 = 0;

  typedef logic [CFU_STATUS_W-1:0] st_t;

  typedef struct {
    bit           sel;
    logic [2:0]   f;
    logic [127:0] a;
    logic [127:0] b;
    logic [127:0] ed;
    st_t          es;
  } vec_t;

  typedef struct {
    logic [127:0] d;
    st_t          s;
    int           c;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        v32, rdy32, rv32, rr32;
  logic [2:0]  f32;
  logic [31:0] a32, b32, d32;
  st_t         s32;
  logic        v64, rdy64, rv64, rr64;
  logic [2:0]  f64;
  logic [63:0] a64, b64, d64;
  st_t         s64;

  exp_t q32[$];
  exp_t q64[$];
  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   lat_on = 1'b1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  popcount_l2_cfu #(
    .CFU_DATA_W (32),
    .PIPE       (P32)
  ) u32 (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (v32),
    .req_ready   (rdy32),
    .req_cfu     (1'b0),
    .req_func    (f32),
    .req_data0   (a32),
    .req_data1   (b32),
    .resp_valid  (rv32),
    .resp_ready  (rr32),
    .resp_status (s32),
    .resp_data   (d32)
  );

  popcount_l2_cfu #(
    .CFU_DATA_W (64),
    .PIPE       (P64)
  ) u64 (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (v64),
    .req_ready   (rdy64),
    .req_cfu     (1'b0),
    .req_func    (f64),
    .req_data0   (a64),
    .req_data1   (b64),
    .resp_valid  (rv64),
    .resp_ready  (rr64),
    .resp_status (s64),
    .resp_data   (d64)
  );

  function automatic void check(
    input string        nm,
    input logic [127:0] act,
    input logic [127:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endfunction

  task automatic add(
    input bit           sel,
    input logic [2:0]   f,
    input logic [127:0] a,
    input logic [127:0] b,
    input logic [127:0] ed,
    input st_t          es
  );
    vec_t v;
    v.sel = sel;
    v.f   = f;
    v.a   = a;
    v.b   = b;
    v.ed  = ed;
    v.es  = es;
    tbl.push_back(v);
  endtask

  task automatic send(input vec_t v);
    int   n;
    bit   ok;
    exp_t e;
    n  = 0;
    ok = 1'b0;
    if (!v.sel) begin
      v32 = 1'b1;
      f32 = v.f;
      a32 = v.a[31:0];
      b32 = v.b[31:0];
    end else begin
      v64 = 1'b1;
      f64 = v.f;
      a64 = v.a[63:0];
      b64 = v.b[63:0];
    end
    while (!ok && n < 50) begin
      @(negedge clk);
      ok = v.sel ? rdy64 : rdy32;
      n++;
    end
    if (ok) begin
      e.d = v.ed;
      e.s = v.es;
      e.c = cyc;
      if (v.sel) q64.push_back(e);
      else q32.push_back(e);
    end else begin
      checks++;
      errors++;
      $display("FAIL send timeout: func %0d never accepted",
               v.f);
    end
    @(posedge clk);
    #1;
    v32 = 1'b0;
    v64 = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q32.size() != 0 || q64.size() != 0)
           && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain pending",
          128'(q32.size() + q64.size()), 128'd0);
  endtask

  // scoreboard for the 32-bit instance
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && rv32 && rr32) begin
      if (q32.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL u32 unexpected response: got %0h required none",
                 d32);
      end else begin
        e = q32.pop_front();
        check("u32 data", 128'(d32), e.d);
        check("u32 status", 128'(s32), 128'(e.s));
        if (lat_on)
          check("u32 latency", 128'(cyc - e.c),
                128'(P32 + 1));
      end
    end
  end

  // scoreboard for the 64-bit instance
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && rv64 && rr64) begin
      if (q64.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL u64 unexpected response: got %0h required none",
                 d64);
      end else begin
        e = q64.pop_front();
        check("u64 data", 128'(d64), e.d);
        check("u64 status", 128'(s64), 128'(e.s));
        if (lat_on)
          check("u64 latency", 128'(cyc - e.c),
                128'(P64 + 1));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t bp[4];
    vec_t v;

    add(0, POP,   128'hFFFF_FFFF, 0, 32, CFU_OK);
    add(0, POP,   128'h8000_0001, 0, 2,  CFU_OK);
    add(0, POP,   128'h0,         0, 0,  CFU_OK);
    add(0, HAMM,  128'h1234_5678,
                  128'hEDCB_A987, 32, CFU_OK);
    add(0, POPAND,128'hFFFF_FFFF, 0, 0,  CFU_OK);
    add(1, POPAND,128'hF0F0_F0F0_F0F0_F0F0,
                  128'hFF00_FF00_FF00_FF00,
                  16, CFU_OK);
    add(1, HAMM,  128'hF0F0_F0F0_F0F0_F0F0,
                  128'hFF00_FF00_FF00_FF00,
                  32, CFU_OK);
    add(1, POP,   128'hFFFF_FFFF_FFFF_FFFF,
                  0, 64, CFU_OK);
    add(1, HAMM,  128'h0123_4567_89AB_CDEF,
                  128'h0123_4567_89AB_CDEF,
                  0, CFU_OK);
    add(0, ACC,   128'hFF, 0, 8,  CFU_OK);
    add(0, ACC,   128'h0F, 0, 12, CFU_OK);
    add(0, ACCRD, 0,       0, 12, CFU_OK);
    add(0, ACC,   128'h1,  0, 1,  CFU_OK);
    add(0, ACC,   128'h7,  0, 4,  CFU_OK);
    add(0, 3'd6,  128'hFFFF_FFFF, 0, 0,
                  CFU_ERROR_CUSTOM);
    add(0, ACCRD, 0, 0, 4, CFU_OK);
    add(0, 3'd5,  128'hF, 0, 0, CFU_ERROR_CUSTOM);
    add(0, 3'd7,  128'hF, 0, 0, CFU_ERROR_CUSTOM);
    add(0, ACCRD, 0, 0, 0, CFU_OK);
    add(1, ACC,   128'hFFFF_FFFF_FFFF_FFFF,
                  0, 64, CFU_OK);
    add(1, ACC,   128'hFFFF_FFFF_FFFF_FFFF,
                  0, 128, CFU_OK);
    add(1, ACCRD, 0, 0, 128, CFU_OK);
    add(1, 3'd7,  128'h3, 0, 0, CFU_ERROR_CUSTOM);
    add(1, ACCRD, 0, 0, 0, CFU_OK);

    rst_n = 1'b0;
    v32 = 1'b0; f32 = '0; a32 = '0; b32 = '0;
    v64 = 1'b0; f64 = '0; a64 = '0; b64 = '0;
    rr32 = 1'b1;
    rr64 = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst u32 resp_valid", 128'(rv32), 128'd0);
    check("rst u32 resp_data", 128'(d32), 128'd0);
    check("rst u32 status", 128'(s32), 128'(CFU_OK));
    check("rst u64 resp_valid", 128'(rv64), 128'd0);
    check("rst u64 resp_data", 128'(d64), 128'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post-rst u32 req_ready",
          128'(rdy32), 128'd1);
    check("post-rst u64 req_ready",
          128'(rdy64), 128'd1);
    @(posedge clk);
    #1;

    for (int i = 0; i < tbl.size(); i++)
      send(tbl[i]);
    drain();

    for (int i = 0; i < 4; i++) begin
      bp[i].sel = 1'b0;
      bp[i].f   = POP;
      bp[i].a   = (128'd1 << (i + 1)) - 128'd1;
      bp[i].b   = '0;
      bp[i].ed  = 128'(i + 1);
      bp[i].es  = CFU_OK;
    end
    lat_on = 1'b0;
    @(posedge clk);
    #1;
    rr32 = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++)
          send(bp[i]);
      end
      begin
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          if (i >= 3) begin
            check("bp req_ready low",
                  128'(rdy32), 128'd0);
            check("bp resp_valid held",
                  128'(rv32), 128'd1);
            check("bp resp_data held",
                  128'(d32), 128'd1);
          end
        end
        @(posedge clk);
        #1;
        rr32 = 1'b1;
      end
    join
    drain();
    lat_on = 1'b1;

    @(posedge clk);
    #1;
    v.sel = 1'b0;
    v.f   = ACC;
    v.a   = 128'hFF;
    v.b   = '0;
    v.ed  = 128'd8;
    v.es  = CFU_OK;
    send(v);
    v.ed  = 128'd16;
    send(v);
    rst_n = 1'b0;
    q32.delete();
    @(negedge clk);
    check("midrst resp_valid", 128'(rv32), 128'd0);
    check("midrst resp_data", 128'(d32), 128'd0);
    check("midrst status", 128'(s32), 128'(CFU_OK));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("flushed resp_valid",
            128'(rv32), 128'd0);
    end
    @(posedge clk);
    #1;
    v.f  = ACCRD;
    v.a  = '0;
    v.ed = 128'd0;
    send(v);
    drain();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
